// File: rtl/axi4_burst_write_master_if.sv
//------------------------------------------------------------------------------
// Module      : axi4_burst_write_master_if
// Description : Command, beat-stream and AXI4 write-channel bundle for the
//               burst write master. "master" is the controller's view,
//               "slave" is the view of whatever sits around it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface axi4_burst_write_master_if #(
  parameter int P_ID_WIDTH   = 6,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 256
);
  // command side
  logic                      WRITE_START;
  logic [P_ADDR_WIDTH-1:0]   WRITE_ADDR;
  logic [7:0]                WRITE_LEN;
  logic                      WRITE_READY;
  // beat stream
  logic [P_DATA_WIDTH-1:0]   WRITE_DATA;
  logic [P_DATA_WIDTH/8-1:0] WRITE_STRB;
  logic                      WRITE_DATA_VALID;
  logic                      WRITE_DATA_READY;
  // completion status
  logic                      WRITE_DONE;
  logic                      WRITE_ERROR;
  logic [1:0]                WRITE_RESP;
  logic [15:0]               ERR_COUNT;
  // AXI4 write address channel
  logic [P_ID_WIDTH-1:0]     M_AXI_AWID;
  logic [P_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [7:0]                M_AXI_AWLEN;
  logic [2:0]                M_AXI_AWSIZE;
  logic [1:0]                M_AXI_AWBURST;
  logic                      M_AXI_AWLOCK;
  logic [3:0]                M_AXI_AWCACHE;
  logic [2:0]                M_AXI_AWPROT;
  logic [3:0]                M_AXI_AWQOS;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  // AXI4 write data channel
  logic [P_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [P_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                      M_AXI_WLAST;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  // AXI4 write response channel
  logic [P_ID_WIDTH-1:0]     M_AXI_BID;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;

  modport master (
    input  WRITE_START, WRITE_ADDR, WRITE_LEN,
    output WRITE_READY,
    input  WRITE_DATA, WRITE_STRB, WRITE_DATA_VALID,
    output WRITE_DATA_READY,
    output WRITE_DONE, WRITE_ERROR, WRITE_RESP, ERR_COUNT,
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    output M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output WRITE_START, WRITE_ADDR, WRITE_LEN,
    input  WRITE_READY,
    output WRITE_DATA, WRITE_STRB, WRITE_DATA_VALID,
    input  WRITE_DATA_READY,
    input  WRITE_DONE, WRITE_ERROR, WRITE_RESP, ERR_COUNT,
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    input  M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi4_burst_write_master.sv
//------------------------------------------------------------------------------
// Module      : axi4_burst_write_master
// Description : Single-outstanding AXI4 INCR burst write master. Accepts a
//               command, issues AW, streams beats through to W, collects B and
//               reports completion / error status. Commands that are too long
//               or would cross a 4 KB page are rejected without AXI traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axi4_burst_write_master #(
  parameter int P_ID_WIDTH   = 6,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 256,
  parameter int P_MAX_LEN    = 16,
  parameter int P_AWID       = 0
) (
  input  wire logic                  CLOCK,
  input  wire logic                  RESET,
  axi4_burst_write_master_if.master  bus
);

  localparam int                      C_BYTES      = P_DATA_WIDTH / 8;
  localparam int                      C_SIZE       = $clog2(C_BYTES);
  localparam logic [P_ADDR_WIDTH-1:0] C_ALIGN_MASK = P_ADDR_WIDTH'(C_BYTES - 1);
  localparam logic [8:0]              C_MAX_BEATS  = 9'(P_MAX_LEN);
  localparam logic [P_ID_WIDTH-1:0]   C_AWID       = P_ID_WIDTH'(P_AWID);
  localparam logic [19:0]             C_PAGE_BYTES = 20'h01000;
  localparam logic [1:0]              C_RESP_OKAY  = 2'b00;
  localparam logic [1:0]              C_RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  state;
  logic                    aw_valid;
  logic [P_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]              cmd_len;
  logic [7:0]              beat_cnt;
  logic                    done;
  logic                    error;
  logic [1:0]              resp;
  logic [15:0]             err_count;

  logic [P_ADDR_WIDTH-1:0] start_addr;
  logic [8:0]              beats;
  logic [19:0]             burst_end;
  logic                    reject;
  logic                    in_data;
  logic                    w_fire;
  logic                    last_beat;
  logic                    b_bad;
  logic [15:0]             err_count_inc;

  // Command legality: the page check uses the aligned start address, since
  // that is what actually goes out on AWADDR.
  always_comb begin
    start_addr    = bus.WRITE_ADDR & ~C_ALIGN_MASK;
    beats         = {1'b0, bus.WRITE_LEN} + 9'd1;
    burst_end     = {8'd0, start_addr[11:0]} + ({11'd0, beats} << C_SIZE);
    reject        = (beats > C_MAX_BEATS) || (burst_end > C_PAGE_BYTES);
    in_data       = (state == S_DATA);
    w_fire        = in_data && bus.WRITE_DATA_VALID && bus.M_AXI_WREADY;
    last_beat     = (beat_cnt == cmd_len);
    b_bad         = (bus.M_AXI_BRESP != C_RESP_OKAY) || (bus.M_AXI_BID != C_AWID);
    err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  end

  // Transaction sequencer with registered AW channel and status outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= S_IDLE;
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      cmd_len   <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      resp      <= '0;
      err_count <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.WRITE_START) begin
            if (reject) begin
              done      <= 1'b1;
              error     <= 1'b1;
              resp      <= C_RESP_SLV;
              err_count <= err_count_inc;
            end else begin
              aw_addr  <= start_addr;
              cmd_len  <= bus.WRITE_LEN;
              aw_valid <= 1'b1;
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.M_AXI_AWREADY) begin
            aw_valid <= 1'b0;
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.M_AXI_BVALID) begin
            done  <= 1'b1;
            resp  <= bus.M_AXI_BRESP;
            state <= S_IDLE;
            if (b_bad) begin
              error     <= 1'b1;
              err_count <= err_count_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command / status outputs.
  assign bus.WRITE_READY      = (state == S_IDLE);
  assign bus.WRITE_DONE       = done;
  assign bus.WRITE_ERROR      = error;
  assign bus.WRITE_RESP       = resp;
  assign bus.ERR_COUNT        = err_count;

  // AW channel: fixed attributes, registered address/length/valid.
  assign bus.M_AXI_AWID       = C_AWID;
  assign bus.M_AXI_AWADDR     = aw_addr;
  assign bus.M_AXI_AWLEN      = cmd_len;
  assign bus.M_AXI_AWSIZE     = 3'(C_SIZE);
  assign bus.M_AXI_AWBURST    = 2'b01;
  assign bus.M_AXI_AWLOCK     = 1'b0;
  assign bus.M_AXI_AWCACHE    = 4'b0011;
  assign bus.M_AXI_AWPROT     = 3'b000;
  assign bus.M_AXI_AWQOS      = 4'b0000;
  assign bus.M_AXI_AWVALID    = aw_valid;

  // W channel is a gated pass-through of the beat stream while in DATA.
  assign bus.M_AXI_WVALID     = in_data && bus.WRITE_DATA_VALID;
  assign bus.WRITE_DATA_READY = in_data && bus.M_AXI_WREADY;
  assign bus.M_AXI_WDATA      = in_data ? bus.WRITE_DATA : '0;
  assign bus.M_AXI_WSTRB      = in_data ? bus.WRITE_STRB : '0;
  assign bus.M_AXI_WLAST      = in_data && last_beat;

  // B channel.
  assign bus.M_AXI_BREADY     = (state == S_RESP);

endmodule

`default_nettype wire
